// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage : N-lane decode with two-entry output skid buffer.
// Optional lane compaction under `DECODE_LANE_COMPACT_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

package d_r_pkg;
   typedef struct packed {
      logic        taken;
      logic [31:0] target;
   } predict_info_t;

   localparam logic [3:0] FU_ALU = 4'b0001;
   localparam logic [3:0] FU_LSU = 4'b0010;
   localparam logic [3:0] FU_BRU = 4'b0100;
   localparam logic [3:0] FU_CSR = 4'b1000;
   localparam logic [1:0] LS_LD  = 2'b01;
   localparam logic [1:0] LS_ST  = 2'b10;

   typedef struct packed {
      logic [4:0]    r_arfid0;
      logic [4:0]    r_arfid1;
      logic [4:0]    w_arfid;
      logic [31:0]   imm;
      logic [3:0]    fu_type;
      logic [1:0]    ls_type;
      logic [13:0]   csr_num;
      logic          decode_err;
      predict_info_t predict;
   } uop_t;
endpackage

module basic_decoder
   import d_r_pkg::*;
(
   input  logic [31:0]   inst_i,
   input  predict_info_t predict_i,
   output uop_t          uop_o
);
   logic [4:0]  rd, rj, rk;
   logic [31:0] si12, ui12, si20, offs16, offs26;

   assign rd     = inst_i[4:0];
   assign rj     = inst_i[9:5];
   assign rk     = inst_i[14:10];
   assign si12   = {{20{inst_i[21]}}, inst_i[21:10]};
   assign ui12   = {20'd0, inst_i[21:10]};
   assign si20   = {inst_i[24:5], 12'd0};
   assign offs16 = {{14{inst_i[25]}}, inst_i[25:10], 2'b00};
   assign offs26 = {{4{inst_i[9]}}, inst_i[9:0], inst_i[25:10], 2'b00};

   always_comb begin
      uop_o         = '0;
      uop_o.predict = predict_i;
      if (inst_i[31:15] inside {17'h20, 17'h22, 17'h24, 17'h25, 17'h28, 17'h29, 17'h2A, 17'h2B}) begin
         uop_o.r_arfid0 = rj;
         uop_o.r_arfid1 = rk;
         uop_o.w_arfid  = rd;
         uop_o.fu_type  = FU_ALU;
      end else if (inst_i[31:22] inside {10'h008, 10'h009, 10'h00A}) begin
         uop_o.r_arfid0 = rj;
         uop_o.w_arfid  = rd;
         uop_o.imm      = si12;
         uop_o.fu_type  = FU_ALU;
      end else if (inst_i[31:22] inside {10'h00D, 10'h00E, 10'h00F}) begin
         uop_o.r_arfid0 = rj;
         uop_o.w_arfid  = rd;
         uop_o.imm      = ui12;
         uop_o.fu_type  = FU_ALU;
      end else if (inst_i[31:22] inside {10'h0A0, 10'h0A1, 10'h0A2, 10'h0A8, 10'h0A9}) begin
         uop_o.r_arfid0 = rj;
         uop_o.w_arfid  = rd;
         uop_o.imm      = si12;
         uop_o.fu_type  = FU_LSU;
         uop_o.ls_type  = LS_LD;
      end else if (inst_i[31:22] inside {10'h0A4, 10'h0A5, 10'h0A6}) begin
         uop_o.r_arfid0 = rj;
         uop_o.r_arfid1 = rd;
         uop_o.imm      = si12;
         uop_o.fu_type  = FU_LSU;
         uop_o.ls_type  = LS_ST;
      end else if (inst_i[31:25] inside {7'h0A, 7'h0E}) begin
         uop_o.w_arfid  = rd;
         uop_o.imm      = si20;
         uop_o.fu_type  = FU_ALU;
      end else if (inst_i[31:26] == 6'h13) begin
         uop_o.r_arfid0 = rj;
         uop_o.w_arfid  = rd;
         uop_o.imm      = offs16;
         uop_o.fu_type  = FU_BRU;
      end else if (inst_i[31:26] == 6'h14) begin
         uop_o.imm      = offs26;
         uop_o.fu_type  = FU_BRU;
      end else if (inst_i[31:26] == 6'h15) begin
         // BL links into r1
         uop_o.w_arfid  = 5'd1;
         uop_o.imm      = offs26;
         uop_o.fu_type  = FU_BRU;
      end else if (inst_i[31:26] inside {6'h16, 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B}) begin
         uop_o.r_arfid0 = rj;
         uop_o.r_arfid1 = rd;
         uop_o.imm      = offs16;
         uop_o.fu_type  = FU_BRU;
      end else if (inst_i[31:24] == 8'h04) begin
         uop_o.csr_num  = inst_i[23:10];
         uop_o.w_arfid  = rd;
         uop_o.fu_type  = FU_CSR;
         if (rj != 5'd0) uop_o.r_arfid1 = rd;
         if (rj > 5'd1)  uop_o.r_arfid0 = rj;
      end else begin
         uop_o.decode_err = 1'b1;
      end
   end
endmodule

module decode_stage
   import d_r_pkg::*;
#(
   parameter int DECODE_WIDTH = 2,
   parameter int BUF_DEPTH    = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               flush_i,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [DECODE_WIDTH-1:0]            in_mask,
   input  logic [31:0]                        in_pc,
   input  logic [DECODE_WIDTH-1:0][31:0]      in_insts,
   input  predict_info_t [DECODE_WIDTH-1:0]   in_predict,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [DECODE_WIDTH-1:0]            out_mask,
   output logic [DECODE_WIDTH-1:0][31:0]      out_pc,
   output uop_t [DECODE_WIDTH-1:0]            out_uop
);
   if (BUF_DEPTH != 2 || DECODE_WIDTH < 1 || DECODE_WIDTH > 8) begin : g_param_chk
      $error("decode_stage: BUF_DEPTH must be 2 and DECODE_WIDTH 1..8");
   end

   logic [DECODE_WIDTH-1:0][31:0] lane_pc;
   uop_t [DECODE_WIDTH-1:0]       dec_uop;

   for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_lane
      assign lane_pc[i] = in_pc + 32'(4 * i);
      basic_decoder u_dec (
         .inst_i    (in_insts[i]),
         .predict_i (in_predict[i]),
         .uop_o     (dec_uop[i])
      );
   end

   logic [DECODE_WIDTH-1:0]       ent_mask_d;
   logic [DECODE_WIDTH-1:0][31:0] ent_pc_d;
   uop_t [DECODE_WIDTH-1:0]       ent_uop_d;

`ifdef DECODE_LANE_COMPACT_EN
   localparam int LW = (DECODE_WIDTH > 1) ? $clog2(DECODE_WIDTH) : 1;
   logic [LW:0] slot;

   // Valid lanes packed downward in order; mask becomes a thermometer code
   always_comb begin
      ent_mask_d = '0;
      ent_pc_d   = '0;
      ent_uop_d  = '0;
      slot       = '0;
      for (int i = 0; i < DECODE_WIDTH; i++) begin
         if (in_mask[i]) begin
            ent_mask_d[slot[LW-1:0]] = 1'b1;
            ent_pc_d[slot[LW-1:0]]   = lane_pc[i];
            ent_uop_d[slot[LW-1:0]]  = dec_uop[i];
            slot                     = slot + (LW+1)'(1);
         end
      end
   end
`else
   always_comb begin
      ent_mask_d = in_mask;
      ent_pc_d   = lane_pc;
      ent_uop_d  = dec_uop;
   end
`endif

   logic       wptr_q, wptr_d, rptr_q, rptr_d;
   logic [1:0] count_q, count_d;
   logic       push, pop;

   logic [DECODE_WIDTH-1:0]       mask_q [2];
   logic [DECODE_WIDTH-1:0][31:0] pc_q   [2];
   uop_t [DECODE_WIDTH-1:0]       uop_q  [2];

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready & ~flush_i & (|in_mask);
   assign pop       = out_valid & out_ready;

   always_comb begin
      count_d = count_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      if (flush_i) begin
         count_d = 2'd0;
         wptr_d  = 1'b0;
         rptr_d  = 1'b0;
      end else begin
         if (push) wptr_d = ~wptr_q;
         if (pop)  rptr_d = ~rptr_q;
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         wptr_q  <= 1'b0;
         rptr_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
      end
   end

   // Payload carries no reset; only the pointers/count qualify it
   always_ff @(posedge clk) begin
      if (push) begin
         mask_q[wptr_q] <= ent_mask_d;
         pc_q[wptr_q]   <= ent_pc_d;
         uop_q[wptr_q]  <= ent_uop_d;
      end
   end

   assign out_mask = out_valid ? mask_q[rptr_q] : '0;
   assign out_pc   = pc_q[rptr_q];
   assign out_uop  = uop_q[rptr_q];
endmodule

`default_nettype wire
